systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
Transmit-side operand feeder for the N x N MAC systolic array. It accepts one operand vector per beat over a valid/ready handshake: N data elements for the west edge and N weight elements for the north edge. It drives the array edges with the diagonal skew the PEs require, where lane i is delayed i cycles relative to lane 0. It also sequences each tile: an accumulator-clear pulse at tile start, a zero-flush drain after the last beat, and a tile_done pulse.

Parameters:
N, 4, array dimension; number of data lanes and weight lanes.
bit_width, 8, operand element width.
DRAIN_CYCLES, 8, extra zero cycles after skew flush to let results propagate out of the array; must be >= 1.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  feeder accepts a beat this cycle
in_last  input  1  final beat (k = K-1) of the current tile
in_data  input  N*bit_width  data vector; lane i = bits [i*bit_width +: bit_width]
in_wt  input  N*bit_width  weight vector; same lane packing
data_out  output  N*bit_width  skewed west-edge data; lane i drives row i data_in
wt_out  output  N*bit_width  skewed north-edge weights; lane i drives column i wt_path_in
lane_valid  output  N  bit i set when lane i carries a real (non-bubble) element
acc_clear  output  1  one-cycle pulse; array accumulator clear at tile start
busy  output  1  high in STREAM, DRAIN or DONE
tile_done  output  1  one-cycle pulse when the tile has fully drained

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state = IDLE; all skew registers = 0; data_out, wt_out, lane_valid = 0; acc_clear, tile_done, busy = 0; drain counter = 0. Reset mid-tile aborts the tile: no tile_done, and no stale data is emitted after reset.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- in_ready = 1 in IDLE and STREAM; in_ready = 0 in DRAIN and DONE.
- Skew: lane i has 1+i register stages. A beat accepted at edge t appears on lane i from edge t+1+i and is held for exactly one cycle.
  - lane_valid[i] travels with the lane data through the same stages.
  - Any cycle with no accepted beat injects zero with lane_valid = 0. Zero operands add nothing to the MAC accumulation, so stalls are transparent to results.
- States:
  - IDLE: on accept, pulse acc_clear in the same cycle and go to STREAM. If in_last is also set (K = 1), go directly to DRAIN.
  - STREAM: each accept without in_last stays in STREAM. An accept with in_last loads drain_cnt = N-1+DRAIN_CYCLES and goes to DRAIN. A cycle with in_valid = 0 is a bubble.
  - DRAIN: inject zeros and decrement drain_cnt each cycle. When drain_cnt = 1, go to DONE.
  - DONE: tile_done = 1 for this single cycle, then IDLE. A new beat is first accepted in the following IDLE cycle.
- Counting from the last-beat edge: N-1+DRAIN_CYCLES DRAIN cycles, then 1 DONE cycle.
- The drain counter is wide enough for N-1+DRAIN_CYCLES (clog2). It never wraps and stops at 0.
- Width rule: the feeder only moves data. There is no arithmetic on operands, and no sign or zero extension.
- in_last with in_valid = 0 is ignored.

Optional Feature:
FEEDER_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0], which counts STREAM cycles with in_valid = 0.
  - Cleared to 0 in the cycle acc_clear pulses.
  - Saturates at 16'hFFFF and holds its value through DRAIN, DONE and IDLE until the next tile start.
  - Reset value is 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- N=4, DRAIN_CYCLES=8. After reset, check all outputs are 0 and in_ready=1. Send 4 back-to-back beats, in_data lanes = {k,k,k,k} for k=1..4 (last beat flagged), accepted at edges t..t+3.
  - acc_clear=1 only in cycle t.
  - Lane 0 shows 1,2,3,4 from edge t+1.
  - Lane 3 shows 1,2,3,4 from edge t+4.
  - lane_valid is 0 in every other cycle.
- Continue the same tile: busy stays high and in_ready=0 for 12 cycles after the last accept (11 DRAIN + 1 DONE). tile_done pulses exactly once, 12 edges after the last accept, then in_ready=1.
- Single beat in IDLE with in_valid=1 and in_last=1, value 0xA5 on all lanes.
  - acc_clear pulses in the same cycle.
  - The state goes straight to DRAIN.
  - 0xA5 appears once on each lane, staggered at t+1..t+4.
  - tile_done pulses at t+12.
- Bubble insertion: beats 7 and 9 with one in_valid=0 cycle between them. Each lane shows 7, 0 (lane_valid=0), 9 in consecutive cycles. With FEEDER_STALL_CNT_EN, stall_cnt = 1.
- Reset mid-DRAIN, asserted 5 cycles after the last beat.
  - Next cycle: all outputs are 0 and in_ready=1.
  - tile_done never pulses.
  - A following tile runs normally.
- Stall saturation (FEEDER_STALL_CNT_EN defined): hold STREAM with in_valid=0 for 70000 cycles. stall_cnt = 16'hFFFF, and it resets to 0 on the next tile's acc_clear.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder and tile sequencer for an N x N MAC array.
// Optional stall counter output: define FEEDER_STALL_CNT_EN.
module systolic_skew_feeder #(
  parameter int N            = 4,
  parameter int bit_width    = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*bit_width-1:0] in_data,
  input  logic [N*bit_width-1:0] in_wt,
  output logic [N*bit_width-1:0] data_out,
  output logic [N*bit_width-1:0] wt_out,
  output logic [N-1:0]           lane_valid,
  output logic                   acc_clear,
  output logic                   busy,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic                   tile_done
);

  localparam int DRAIN_LOAD = N - 1 + DRAIN_CYCLES;
  localparam int CW = $clog2(DRAIN_LOAD + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   drain_cnt;
  logic            accept;

  assign in_ready  = (state == IDLE) || (state == STREAM);
  assign accept    = in_valid && in_ready && !reset;
  assign acc_clear = accept && (state == IDLE);

  // Tile sequencer: stream beats, flush the skew and array, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (in_last) begin
              state     <= DRAIN;
              drain_cnt <= CW'(DRAIN_LOAD);
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            state     <= DRAIN;
            drain_cnt <= CW'(DRAIN_LOAD);
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end
          if (drain_cnt <= CW'(1)) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [bit_width-1:0] dq [i+1];
    logic [bit_width-1:0] wq [i+1];
    logic                 vq [i+1];

    // Lane i delay line of 1+i stages; idle cycles inject zero bubbles.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j <= i; j++) begin
          dq[j] <= '0;
          wq[j] <= '0;
          vq[j] <= 1'b0;
        end
      end else begin
        dq[0] <= accept ? in_data[i*bit_width +: bit_width] : '0;
        wq[0] <= accept ? in_wt[i*bit_width +: bit_width] : '0;
        vq[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          dq[j] <= dq[j-1];
          wq[j] <= wq[j-1];
          vq[j] <= vq[j-1];
        end
      end
    end

    assign data_out[i*bit_width +: bit_width] = dq[i];
    assign wt_out[i*bit_width +: bit_width]   = wq[i];
    assign lane_valid[i]                      = vq[i];
  end

`ifdef FEEDER_STALL_CNT_EN
  // Count input starvation while streaming; saturating, held until next tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (acc_clear) begin
      stall_cnt <= '0;
    end else if (state == STREAM && !in_valid &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed testbench for systolic_skew_feeder (N=4, DRAIN_CYCLES=8).
// Samples outputs at the falling edge, i.e. the value seen by the next rise.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int NW = N * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [NW-1:0] in_data;
  logic [NW-1:0] in_wt;
  logic [NW-1:0] data_out;
  logic [NW-1:0] wt_out;
  logic [N-1:0]  lane_valid;
  logic          acc_clear;
  logic          busy;
  logic          tile_done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  systolic_skew_feeder #(
    .N(N), .bit_width(BW), .DRAIN_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .in_data(in_data),
    .in_wt(in_wt),
    .data_out(data_out),
    .wt_out(wt_out),
    .lane_valid(lane_valid),
    .acc_clear(acc_clear),
    .busy(busy),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [NW-1:0] s_d [32];
  logic [NW-1:0] s_w [32];
  logic          s_v [32];
  logic          s_l [32];
  int            s_n;

  logic [NW-1:0] o_d, o_w;
  logic [N-1:0]  o_v;
  logic          o_clr, o_busy, o_rdy, o_done;

  // One clock cycle: drive inputs, sample at negedge, end 1ns after rise.
  task automatic cyc(input logic v, input logic l,
                     input logic [NW-1:0] d, input logic [NW-1:0] w,
                     input logic rst);
    reset    = rst;
    in_valid = v;
    in_last  = l;
    in_data  = d;
    in_wt    = w;
    @(negedge clk);
    o_d    = data_out;
    o_w    = wt_out;
    o_v    = lane_valid;
    o_clr  = acc_clear;
    o_busy = busy;
    o_rdy  = in_ready;
    o_done = tile_done;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c);
    if (c < s_n) cyc(s_v[c], s_l[c], s_d[c], s_w[c], 1'b0);
    else cyc(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Lane i seen before rise c carries the beat offered in cycle c-1-i.
  function automatic logic [NW-1:0] exp_vec(input int c, input bit wt);
    logic [NW-1:0] r;
    int b;
    r = '0;
    for (int i = 0; i < N; i++) begin
      b = c - 1 - i;
      if (b >= 0 && b < s_n) begin
        if (s_v[b]) begin
          if (wt) r[i*BW +: BW] = s_w[b][i*BW +: BW];
          else r[i*BW +: BW] = s_d[b][i*BW +: BW];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_val(input int c);
    logic [N-1:0] r;
    int b;
    r = '0;
    for (int i = 0; i < N; i++) begin
      b = c - 1 - i;
      if (b >= 0 && b < s_n) r[i] = s_v[b];
    end
    return r;
  endfunction

  task automatic test_reset();
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
    checks += 7;
    if (o_d !== '0) begin
      errors++; $display("FAIL rst data_out got=%h exp=0", o_d);
    end
    if (o_w !== '0) begin
      errors++; $display("FAIL rst wt_out got=%h exp=0", o_w);
    end
    if (o_v !== '0) begin
      errors++; $display("FAIL rst lane_valid got=%b exp=0", o_v);
    end
    if (o_clr !== 1'b0) begin
      errors++; $display("FAIL rst acc_clear got=%b exp=0", o_clr);
    end
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL rst busy got=%b exp=0", o_busy);
    end
    if (o_done !== 1'b0) begin
      errors++; $display("FAIL rst tile_done got=%b exp=0", o_done);
    end
    if (o_rdy !== 1'b1) begin
      errors++; $display("FAIL rst in_ready got=%b exp=1", o_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    s_n = 4;
    lc  = 3;
    for (int k = 0; k < 4; k++) begin
      s_v[k] = 1'b1;
      s_l[k] = (k == 3);
      s_d[k] = {4{8'(k + 1)}};
      for (int i = 0; i < N; i++) s_w[k][i*BW +: BW] = 8'(16 * (k + 1) + i);
    end
    for (int c = 0; c <= lc + 13; c++) begin
      drive(c);
      checks += 7;
      if (o_d !== exp_vec(c, 0)) begin
        errors++;
        $display("FAIL b2b data c=%0d got=%h exp=%h", c, o_d, exp_vec(c, 0));
      end
      if (o_w !== exp_vec(c, 1)) begin
        errors++;
        $display("FAIL b2b wt c=%0d got=%h exp=%h", c, o_w, exp_vec(c, 1));
      end
      if (o_v !== exp_val(c)) begin
        errors++;
        $display("FAIL b2b valid c=%0d got=%b exp=%b", c, o_v, exp_val(c));
      end
      if (o_clr !== (c == 0)) begin
        errors++; $display("FAIL b2b acc_clear c=%0d got=%b", c, o_clr);
      end
      if (o_busy !== (c >= 1 && c <= lc + 12)) begin
        errors++; $display("FAIL b2b busy c=%0d got=%b", c, o_busy);
      end
      if (o_rdy !== (c <= lc || c >= lc + 13)) begin
        errors++; $display("FAIL b2b in_ready c=%0d got=%b", c, o_rdy);
      end
      if (o_done !== (c == lc + 12)) begin
        errors++; $display("FAIL b2b tile_done c=%0d got=%b", c, o_done);
      end
    end
  endtask

  task automatic test_single_beat();
    int lc;
    s_n = 1;
    lc  = 0;
    s_v[0] = 1'b1;
    s_l[0] = 1'b1;
    s_d[0] = 32'hA5A5_A5A5;
    s_w[0] = 32'h5A3C_1E0F;
    for (int c = 0; c <= lc + 13; c++) begin
      drive(c);
      checks += 7;
      if (o_d !== exp_vec(c, 0)) begin
        errors++;
        $display("FAIL k1 data c=%0d got=%h exp=%h", c, o_d, exp_vec(c, 0));
      end
      if (o_w !== exp_vec(c, 1)) begin
        errors++;
        $display("FAIL k1 wt c=%0d got=%h exp=%h", c, o_w, exp_vec(c, 1));
      end
      if (o_v !== exp_val(c)) begin
        errors++;
        $display("FAIL k1 valid c=%0d got=%b exp=%b", c, o_v, exp_val(c));
      end
      if (o_clr !== (c == 0)) begin
        errors++; $display("FAIL k1 acc_clear c=%0d got=%b", c, o_clr);
      end
      if (o_busy !== (c >= 1 && c <= lc + 12)) begin
        errors++; $display("FAIL k1 busy c=%0d got=%b", c, o_busy);
      end
      if (o_rdy !== (c <= lc || c >= lc + 13)) begin
        errors++; $display("FAIL k1 in_ready c=%0d got=%b", c, o_rdy);
      end
      if (o_done !== (c == lc + 12)) begin
        errors++; $display("FAIL k1 tile_done c=%0d got=%b", c, o_done);
      end
    end
  endtask

  task automatic test_bubble();
    int lc;
    s_n = 3;
    lc  = 2;
    s_v[0] = 1'b1; s_l[0] = 1'b0;
    s_d[0] = {4{8'd7}}; s_w[0] = 32'h7172_7374;
    s_v[1] = 1'b0; s_l[1] = 1'b1;
    s_d[1] = 32'hDEAD_BEEF; s_w[1] = 32'hCAFE_F00D;
    s_v[2] = 1'b1; s_l[2] = 1'b1;
    s_d[2] = {4{8'd9}}; s_w[2] = 32'h9192_9394;
    for (int c = 0; c <= lc + 13; c++) begin
      drive(c);
      checks += 7;
      if (o_d !== exp_vec(c, 0)) begin
        errors++;
        $display("FAIL bub data c=%0d got=%h exp=%h", c, o_d, exp_vec(c, 0));
      end
      if (o_w !== exp_vec(c, 1)) begin
        errors++;
        $display("FAIL bub wt c=%0d got=%h exp=%h", c, o_w, exp_vec(c, 1));
      end
      if (o_v !== exp_val(c)) begin
        errors++;
        $display("FAIL bub valid c=%0d got=%b exp=%b", c, o_v, exp_val(c));
      end
      if (o_clr !== (c == 0)) begin
        errors++; $display("FAIL bub acc_clear c=%0d got=%b", c, o_clr);
      end
      if (o_busy !== (c >= 1 && c <= lc + 12)) begin
        errors++; $display("FAIL bub busy c=%0d got=%b", c, o_busy);
      end
      if (o_rdy !== (c <= lc || c >= lc + 13)) begin
        errors++; $display("FAIL bub in_ready c=%0d got=%b", c, o_rdy);
      end
      if (o_done !== (c == lc + 12)) begin
        errors++; $display("FAIL bub tile_done c=%0d got=%b", c, o_done);
      end
    end
`ifdef FEEDER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL bub stall_cnt got=%0d exp=1", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    s_n = 4;
    for (int k = 0; k < 4; k++) begin
      s_v[k] = 1'b1;
      s_l[k] = (k == 3);
      s_d[k] = {4{8'(8'h20 + k)}};
      s_w[k] = {4{8'(8'h30 + k)}};
    end
    for (int c = 0; c < 8; c++) drive(c);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL rmid busy before reset got=%b exp=1", o_busy);
    end
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
    checks += 6;
    if (o_d !== '0 || o_w !== '0) begin
      errors++; $display("FAIL rmid data got=%h/%h exp=0", o_d, o_w);
    end
    if (o_v !== '0) begin
      errors++; $display("FAIL rmid lane_valid got=%b exp=0", o_v);
    end
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL rmid busy got=%b exp=0", o_busy);
    end
    if (o_rdy !== 1'b1) begin
      errors++; $display("FAIL rmid in_ready got=%b exp=1", o_rdy);
    end
    if (o_clr !== 1'b0) begin
      errors++; $display("FAIL rmid acc_clear got=%b exp=0", o_clr);
    end
    if (o_done !== 1'b0) begin
      errors++; $display("FAIL rmid tile_done got=%b exp=0", o_done);
    end
    for (int c = 0; c < 15; c++) begin
      cyc(1'b0, 1'b0, '0, '0, 1'b0);
      checks += 2;
      if (o_done !== 1'b0) begin
        errors++; $display("FAIL rmid stray tile_done c=%0d", c);
      end
      if (o_v !== '0) begin
        errors++; $display("FAIL rmid stray lane_valid c=%0d got=%b", c, o_v);
      end
    end
  endtask

`ifdef FEEDER_STALL_CNT_EN
  task automatic test_stall_sat();
    cyc(1'b1, 1'b0, 32'h0101_0101, 32'h0202_0202, 1'b0);
    in_valid = 1'b0;
    in_data  = '0;
    in_wt    = '0;
    repeat (70000) @(posedge clk);
    #1;
    checks += 2;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat stall_cnt got=%h exp=ffff", stall_cnt);
    end
    if (busy !== 1'b1) begin
      errors++; $display("FAIL sat busy got=%b exp=1", busy);
    end
    cyc(1'b1, 1'b1, 32'h0303_0303, 32'h0404_0404, 1'b0);
    for (int c = 0; c < 13; c++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    checks += 2;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat hold got=%h exp=ffff", stall_cnt);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL sat in_ready got=%b exp=1", in_ready);
    end
    cyc(1'b1, 1'b1, 32'h0505_0505, 32'h0606_0606, 1'b0);
    checks += 2;
    if (o_clr !== 1'b1) begin
      errors++; $display("FAIL sat acc_clear got=%b exp=1", o_clr);
    end
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL sat clear got=%h exp=0", stall_cnt);
    end
    for (int c = 0; c < 13; c++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
  endtask
`endif

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    in_wt    = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_single_beat();
    test_bubble();
    test_reset_mid();
    test_single_beat();
`ifdef FEEDER_STALL_CNT_EN
    test_stall_sat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
